// File: rtl/axi4_lite_wr_path_slave_pkg.sv
// rtl/axi4_lite_wr_path_slave_pkg.sv - shared types and default widths for the AXI4-Lite write path
// Purpose: response encoding and default bus widths used by the write-path slave and its bench.
package axi4_lite_wr_path_slave_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

endpackage

// File: rtl/axi4_lite_wr_path_slave_sync_fifo.sv
// rtl/axi4_lite_wr_path_slave_sync_fifo.sv - synchronous FIFO used for the AW, W and B channels
// Purpose: DEPTH-entry single-clock FIFO with push/pop/full/empty handshake.
// Ports:
//   i_clk, i_rst      clock and synchronous active-high reset (flushes contents)
//   i_push, i_din     write request and data; ignored while full (even if popping)
//   i_pop, o_dout     read request and head entry; ignored while empty
//   o_full, o_empty   status derived only from the pointer registers
module axi4_lite_wr_path_slave_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Pointers carry one extra wrap bit: equal index with differing wrap bit means full.
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr[PW-1:0]] <= i_din;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_wr_path_slave.sv
// rtl/axi4_lite_wr_path_slave.sv - AXI4-Lite slave write path with independent AW/W/B buffering
// Purpose: accepts AW and W in any order, pairs them in arrival order, applies byte strobes
// to the storage port and returns one B response per write.
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   AWADDR/AWVALID/AWREADY       write address channel
//   WDATA/WSTRB/WVALID/WREADY    write data channel
//   BRESP/BVALID/BREADY          write response channel (OKAY or SLVERR)
//   mem_we/addr/wdata/wstrb      registered one-cycle storage write command
//   err_cnt                      saturating count of SLVERR responses
module axi4_lite_wr_path_slave
  import axi4_lite_wr_path_slave_pkg::*;
#(
  parameter  int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter  int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter  int AW_DEPTH   = 4,
  parameter  int W_DEPTH    = 4,
  parameter  int B_DEPTH    = 2,
  parameter  int MEM_WORDS  = 1024,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int MEM_AW     = $clog2(MEM_WORDS)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic [7:0]            err_cnt
);

  localparam int LANE_SHIFT = $clog2(STRB_WIDTH);

  logic                             w_aw_full;
  logic                             w_aw_empty;
  logic                             w_w_full;
  logic                             w_w_empty;
  logic                             w_b_full;
  logic                             w_b_empty;
  logic [ADDR_WIDTH-1:0]            w_aw_head;
  logic [DATA_WIDTH+STRB_WIDTH-1:0] w_w_head;
  logic [1:0]                       w_b_head;
  logic [DATA_WIDTH-1:0]            w_head_data;
  logic [STRB_WIDTH-1:0]            w_head_strb;
  logic [ADDR_WIDTH-1:0]            w_idx;
  logic                             w_in_range;
  logic                             w_commit;
  resp_t                            w_resp;

  // READY depends only on registered FIFO state and reset, never on VALID.
  assign AWREADY = !w_aw_full && !ARESET;
  assign WREADY  = !w_w_full && !ARESET;

  assign {w_head_data, w_head_strb} = w_w_head;

  // One write retires per cycle once both heads exist and a response slot is free.
  assign w_commit   = !w_aw_empty && !w_w_empty && !w_b_full;
  assign w_idx      = w_aw_head >> LANE_SHIFT;
  assign w_in_range = (w_idx < ADDR_WIDTH'(MEM_WORDS));
  assign w_resp     = w_in_range ? RESP_OKAY : RESP_SLVERR;

  assign BVALID = !w_b_empty;
  // The FIFO storage is not reset, so mask the head while nothing is queued.
  assign BRESP  = w_b_empty ? 2'b00 : w_b_head;

  axi4_lite_wr_path_slave_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .i_clk  (ACLK),
    .i_rst  (ARESET),
    .i_push (AWVALID && AWREADY),
    .i_din  (AWADDR),
    .i_pop  (w_commit),
    .o_dout (w_aw_head),
    .o_full (w_aw_full),
    .o_empty(w_aw_empty)
  );

  axi4_lite_wr_path_slave_sync_fifo #(.WIDTH(DATA_WIDTH + STRB_WIDTH), .DEPTH(W_DEPTH)) u_w_fifo (
    .i_clk  (ACLK),
    .i_rst  (ARESET),
    .i_push (WVALID && WREADY),
    .i_din  ({WDATA, WSTRB}),
    .i_pop  (w_commit),
    .o_dout (w_w_head),
    .o_full (w_w_full),
    .o_empty(w_w_empty)
  );

  axi4_lite_wr_path_slave_sync_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b_fifo (
    .i_clk  (ACLK),
    .i_rst  (ARESET),
    .i_push (w_commit),
    .i_din  (w_resp),
    .i_pop  (BVALID && BREADY),
    .o_dout (w_b_head),
    .o_full (w_b_full),
    .o_empty(w_b_empty)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      err_cnt   <= 8'd0;
    end else begin
      // An all-zero strobe still earns OKAY but must not touch storage.
      mem_we <= w_commit && w_in_range && (w_head_strb != '0);
      if (w_commit) begin
        mem_addr  <= w_idx[MEM_AW-1:0];
        mem_wdata <= w_head_data;
        mem_wstrb <= w_head_strb;
        if (!w_in_range && (err_cnt != 8'hFF)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_wr_path_slave.sv
// tb/tb_axi4_lite_wr_path_slave.sv - self-checking bench for the AXI4-Lite write path slave
module tb_axi4_lite_wr_path_slave;
  import axi4_lite_wr_path_slave_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [7:0]  err_cnt;

  always #5 ACLK = ~ACLK;

  axi4_lite_wr_path_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        exp_we;
    logic [9:0]  exp_addr;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[8];

  // Reference model: pending AW/W queues paired strictly in arrival order.
  logic [31:0] aw_send[$];
  wr_t         w_send[$];
  logic [31:0] aw_pend[$];
  wr_t         w_pend[$];
  wr_t         exp_wr[$];
  logic [1:0]  exp_b[$];
  int          err_model;
  int          acc_aw;
  int          acc_w;
  bit          rnd_valid;
  int          bready_mode;
  bit          aw_hold;
  bit          w_hold;
  bit          prev_stall;
  logic [1:0]  prev_resp;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_pair();
    logic [31:0] a;
    wr_t w;
    wr_t e;
    while (aw_pend.size() != 0 && w_pend.size() != 0) begin
      a = aw_pend.pop_front();
      w = w_pend.pop_front();
      if ((a >> 2) < 32'd1024) begin
        exp_b.push_back(2'b00);
        if (w.strb != 4'h0) begin
          e.addr = a >> 2;
          e.data = w.data;
          e.strb = w.strb;
          exp_wr.push_back(e);
        end
      end else begin
        exp_b.push_back(2'b10);
        if (err_model < 255) err_model++;
      end
    end
  endfunction

  function automatic bit model_idle();
    return aw_send.size() == 0 && w_send.size() == 0 && aw_pend.size() == 0 &&
           w_pend.size() == 0 && exp_wr.size() == 0 && exp_b.size() == 0;
  endfunction

  task automatic clear_model();
    aw_send.delete(); w_send.delete(); aw_pend.delete(); w_pend.delete();
    exp_wr.delete(); exp_b.delete();
    err_model = 0; acc_aw = 0; acc_w = 0;
    aw_hold = 1'b0; w_hold = 1'b0; prev_stall = 1'b0; prev_resp = 2'b00;
  endtask

  task automatic add_pair(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wr_t w;
    w.addr = addr; w.data = data; w.strb = strb;
    aw_send.push_back(addr);
    w_send.push_back(w);
  endtask

  task automatic step();
    wr_t e;
    @(negedge ACLK);
    if (prev_stall) begin
      chk("b_hold_valid", BVALID, 1);
      chk("b_hold_resp", BRESP, prev_resp);
    end
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_we got=1 exp=0 addr=%0h", mem_addr);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_strb", mem_wstrb, e.strb);
      end
    end
    if (!aw_hold) begin
      if (aw_send.size() != 0 && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
        AWVALID = 1'b1; AWADDR = aw_send[0];
      end else begin
        AWVALID = 1'b0; AWADDR = $urandom;
      end
    end
    if (!w_hold) begin
      if (w_send.size() != 0 && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
        WVALID = 1'b1; WDATA = w_send[0].data; WSTRB = w_send[0].strb;
      end else begin
        WVALID = 1'b0; WDATA = $urandom; WSTRB = 4'($urandom_range(0, 15));
      end
    end
    case (bready_mode)
      0:       BREADY = 1'b0;
      1:       BREADY = 1'b1;
      default: BREADY = ($urandom_range(0, 1) == 1);
    endcase
    #1;
    if (AWVALID && AWREADY) begin
      aw_pend.push_back(aw_send.pop_front()); acc_aw++; aw_hold = 1'b0;
    end else aw_hold = AWVALID;
    if (WVALID && WREADY) begin
      w_pend.push_back(w_send.pop_front()); acc_w++; w_hold = 1'b0;
    end else w_hold = WVALID;
    model_pair();
    if (BVALID && BREADY) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_b got=%0h exp=none", BRESP);
      end else chk("b_resp", BRESP, exp_b.pop_front());
    end
    prev_stall = BVALID && !BREADY;
    prev_resp  = BRESP;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin
      step();
      n++;
    end
    if (!model_idle()) begin
      checks++; failures++;
      $display("FAIL timeout got=busy exp=idle pend_b=%0d pend_wr=%0d", exp_b.size(), exp_wr.size());
    end
    step();
    step();
    chk("err_cnt_model", err_cnt, 64'(err_model));
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    clear_model();
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge ACLK);
    AWADDR = v.addr; WDATA = v.data; WSTRB = v.strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    #1;
    chk("vec_ready", {AWREADY, WREADY}, 2'b11);
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("vec_lat_we", mem_we, 0);
    chk("vec_lat_bvalid", BVALID, 0);
    @(negedge ACLK);
    chk("vec_we", mem_we, v.exp_we);
    if (v.exp_we) begin
      chk("vec_addr", mem_addr, v.exp_addr);
      chk("vec_data", mem_wdata, v.data);
      chk("vec_strb", mem_wstrb, v.strb);
    end
    chk("vec_bvalid", BVALID, 1);
    chk("vec_bresp", BRESP, v.exp_resp);
    @(negedge ACLK);
    chk("vec_bdone", BVALID, 0);
    chk("vec_we_once", mem_we, 0);
    chk("vec_err", err_cnt, v.exp_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int bcnt;
    logic [31:0] a;

    vecs[0] = '{32'h0000_0579, 32'h00AB_CDEF, 4'hF, 1'b1, 10'h15E, 2'b00, 8'd0};
    vecs[1] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'h0, 1'b0, 10'h000, 2'b00, 8'd0};
    vecs[2] = '{32'h0000_1000, 32'h1234_5678, 4'hF, 1'b0, 10'h000, 2'b10, 8'd1};
    vecs[3] = '{32'h0000_0FFC, 32'hCAFE_F00D, 4'h8, 1'b1, 10'h3FF, 2'b00, 8'd1};
    vecs[4] = '{32'h0000_0FFF, 32'h0BAD_F00D, 4'h1, 1'b1, 10'h3FF, 2'b00, 8'd1};
    vecs[5] = '{32'h0000_1004, 32'h0000_0001, 4'hF, 1'b0, 10'h000, 2'b10, 8'd2};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0002, 4'h3, 1'b0, 10'h000, 2'b10, 8'd3};
    vecs[7] = '{32'h0000_0000, 32'hA5A5_A5A5, 4'h6, 1'b1, 10'h000, 2'b00, 8'd3};

    ARESET = 1'b1; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0;
    WVALID = 1'b0; BREADY = 1'b0;
    rnd_valid = 1'b0; bready_mode = 1;
    clear_model();

    repeat (2) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_err_cnt", err_cnt, 0);
    ARESET = 1'b0;
    #1;
    chk("ready_after_reset", {AWREADY, WREADY}, 2'b11);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // W arrives three cycles ahead of its address.
    do_reset();
    @(negedge ACLK);
    WDATA = 32'h1122_3344; WSTRB = 4'b0101; WVALID = 1'b1; BREADY = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("t2_early_we0", mem_we, 0);
    @(negedge ACLK);
    chk("t2_early_we1", mem_we, 0);
    @(negedge ACLK);
    chk("t2_early_we2", mem_we, 0);
    AWADDR = 32'h8; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("t2_lat_we", mem_we, 0);
    @(negedge ACLK);
    chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 2);
    chk("t2_data", mem_wdata, 32'h1122_3344);
    chk("t2_strb", mem_wstrb, 4'b0101);
    chk("t2_bresp", BRESP, 0);
    bcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (BVALID && BREADY) bcnt++;
      @(negedge ACLK);
    end
    chk("t2_one_b", bcnt, 1);

    // Backpressure: B stalled, 8 pairs offered, READY must drop after 6.
    do_reset();
    rnd_valid = 1'b0; bready_mode = 0;
    for (int i = 0; i < 8; i++) begin
      a = (i == 1 || i == 4 || i == 5 || i == 7) ? 32'h2000 + 32'(i * 4) : 32'(i * 8);
      add_pair(a, $urandom, 4'hF);
    end
    run_cycles(14);
    chk("t3_acc_aw", acc_aw, 6);
    chk("t3_acc_w", acc_w, 6);
    chk("t3_awready", AWREADY, 0);
    chk("t3_wready", WREADY, 0);
    chk("t3_bvalid", BVALID, 1);
    chk("t3_bresp_head", BRESP, 2'b00);
    bready_mode = 1;
    run_until_idle(300);

    // Out-of-range writes and error-count saturation.
    do_reset();
    bready_mode = 1;
    add_pair(32'h1000, 32'h5555_AAAA, 4'hF);
    run_until_idle(50);
    chk("t4_err_one", err_cnt, 1);
    rnd_valid = 1'b1; bready_mode = 2;
    for (int i = 0; i < 299; i++) add_pair($urandom_range(32'h1000, 32'hFFFF_FFFF), $urandom, 4'($urandom_range(0, 15)));
    run_until_idle(5000);
    chk("t4_err_sat", err_cnt, 8'hFF);

    // Reset with work in flight.
    do_reset();
    rnd_valid = 1'b0; bready_mode = 0;
    for (int i = 0; i < 3; i++) add_pair(32'(i * 4), $urandom, 4'hF);
    aw_send.push_back(32'h40);
    run_cycles(8);
    chk("t6_pre_bvalid", BVALID, 1);
    chk("t6_pre_acc", {acc_aw[7:0], acc_w[7:0]}, 16'h0403);
    @(negedge ACLK);
    ARESET = 1'b1; AWVALID = 1'b0; WVALID = 1'b0;
    #1;
    chk("t6_rst_awready", AWREADY, 0);
    chk("t6_rst_wready", WREADY, 0);
    @(negedge ACLK);
    chk("t6_bvalid", BVALID, 0);
    chk("t6_we", mem_we, 0);
    chk("t6_ready_held", {AWREADY, WREADY}, 2'b00);
    ARESET = 1'b0;
    clear_model();
    BREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("t6_no_stale_we", mem_we, 0);
      chk("t6_no_stale_b", BVALID, 0);
    end
    bready_mode = 1;
    add_pair(32'h24, 32'h0F0F_1234, 4'hF);
    run_until_idle(50);

    // Randomized traffic against the reference model.
    do_reset();
    rnd_valid = 1'b1; bready_mode = 2;
    for (int i = 0; i < 300; i++) add_pair($urandom_range(0, 32'h13FF), $urandom, 4'($urandom_range(0, 15)));
    run_until_idle(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
